// File: rtl/shift_reg_univ_pkg.sv
// Shared types for the universal shift register: operation modes and mode helpers.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    SR_HOLD  = 3'd0,
    SR_SHL   = 3'd1,
    SR_SHR   = 3'd2,
    SR_ROL   = 3'd3,
    SR_ROR   = 3'd4,
    SR_LOAD  = 3'd5,
    SR_CLEAR = 3'd6,
    SR_RSVD  = 3'd7
  } sr_mode_e;

  function automatic logic is_shift(input sr_mode_e m);
    return (m == SR_SHL) || (m == SR_SHR) || (m == SR_ROL) || (m == SR_ROR);
  endfunction

  function automatic logic is_reframe(input sr_mode_e m);
    return (m == SR_LOAD) || (m == SR_CLEAR);
  endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle between a driver (master) and the universal shift register (slave).
interface shift_reg_univ_if
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic             en_i;
  sr_mode_e         mode_i;
  logic [WIDTH-1:0] load_data_i;
  logic             sin_lsb_i;
  logic             sin_msb_i;
  logic [WIDTH-1:0] sr_o;
  logic             sout_msb_o;
  logic             sout_lsb_o;
  logic [CW-1:0]    cnt_o;
  logic             frame_done_o;

  modport master (
    output en_i, mode_i, load_data_i, sin_lsb_i, sin_msb_i,
    input  sr_o, sout_msb_o, sout_lsb_o, cnt_o, frame_done_o
  );

  modport slave (
    input  en_i, mode_i, load_data_i, sin_lsb_i, sin_msb_i,
    output sr_o, sout_msb_o, sout_lsb_o, cnt_o, frame_done_o
  );

endinterface

// File: rtl/shift_reg_univ_frame_cnt.sv
// Per-frame shift counter: wraps after WIDTH shifts and emits a registered one-cycle done pulse.
module shift_frame_cnt #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // clr wins over inc so a reload at the last count never reports a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: shift, rotate, load, clear, with frame counting.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input logic              clk,
  input logic              reset,
  shift_reg_univ_if.slave  bus
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
    $error("shift_reg_univ: WIDTH must be in 2..64");
  end

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             inc;
  logic             clr;

  always_comb begin
    sr_d = sr_q;
    if (bus.en_i) begin
      unique case (bus.mode_i)
        SR_SHL:   sr_d = {sr_q[WIDTH-2:0], bus.sin_lsb_i};
        SR_SHR:   sr_d = {bus.sin_msb_i, sr_q[WIDTH-1:1]};
        SR_ROL:   sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        SR_ROR:   sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
        SR_LOAD:  sr_d = bus.load_data_i;
        SR_CLEAR: sr_d = '0;
        default:  sr_d = sr_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= RESET_VAL;
    else       sr_q <= sr_d;
  end

  assign inc = bus.en_i && is_shift(bus.mode_i);
  assign clr = bus.en_i && is_reframe(bus.mode_i);

  shift_frame_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .clr   (clr),
    .cnt   (bus.cnt_o),
    .done  (bus.frame_done_o)
  );

  assign bus.sr_o       = sr_q;
  assign bus.sout_msb_o = sr_q[WIDTH-1];
  assign bus.sout_lsb_o = sr_q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ (WIDTH=8): directed vectors with hand-computed results.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  typedef struct packed {
    logic [7:0] sr;
    logic [2:0] cnt;
    logic       done;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  shift_reg_univ_if #(.WIDTH(8)) bus0 ();
  shift_reg_univ_if #(.WIDTH(8)) bus1 ();

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hFF)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus1.en_i        = bus0.en_i;
  assign bus1.mode_i      = bus0.mode_i;
  assign bus1.load_data_i = bus0.load_data_i;
  assign bus1.sin_lsb_i   = bus0.sin_lsb_i;
  assign bus1.sin_msb_i   = bus0.sin_msb_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare once per issued vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sr_o",         32'(bus0.sr_o),         32'(e.sr));
        check("cnt_o",        32'(bus0.cnt_o),        32'(e.cnt));
        check("frame_done_o", 32'(bus0.frame_done_o), 32'(e.done));
      end
    end
  end

  task automatic step(input logic en, input sr_mode_e mode, input logic [7:0] ld,
                      input logic sl, input logic sm,
                      input logic [7:0] e_sr, input logic [2:0] e_cnt, input logic e_done);
    exp_t e;
    @(negedge clk);
    bus0.en_i        = en;
    bus0.mode_i      = mode;
    bus0.load_data_i = ld;
    bus0.sin_lsb_i   = sl;
    bus0.sin_msb_i   = sm;
    e.sr   = e_sr;
    e.cnt  = e_cnt;
    e.done = e_done;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus0.en_i        = 1'b0;
    bus0.mode_i      = SR_HOLD;
    bus0.load_data_i = '0;
    bus0.sin_lsb_i   = 1'b0;
    bus0.sin_msb_i   = 1'b0;
    checks = 0;
    errors = 0;

    #2;
    check("reset sr_o",      32'(bus0.sr_o), 32'h00);
    check("reset cnt_o",     32'(bus0.cnt_o), 32'h0);
    check("reset frame_done",32'(bus0.frame_done_o), 32'h0);
    check("reset RESET_VAL", 32'(bus1.sr_o), 32'hFF);
    @(negedge clk);
    reset = 1'b0;

    // LOAD then SHL with sin_lsb=1
    step(1, SR_LOAD, 8'hA5, 0, 0, 8'hA5, 3'd0, 0);
    drain();
    check("sout_msb before SHL", 32'(bus0.sout_msb_o), 32'h1);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h4B, 3'd1, 0);

    // Rotates
    step(1, SR_LOAD, 8'h81, 0, 0, 8'h81, 3'd0, 0);
    drain();
    check("sout_lsb before ROR", 32'(bus0.sout_lsb_o), 32'h1);
    step(1, SR_ROR, 8'h00, 0, 0, 8'hC0, 3'd1, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'h81, 3'd2, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'h03, 3'd3, 0);

    // Full frame of SHL filling with ones
    step(1, SR_LOAD, 8'h00, 0, 0, 8'h00, 3'd0, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h01, 3'd1, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h03, 3'd2, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h07, 3'd3, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h0F, 3'd4, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h1F, 3'd5, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h3F, 3'd6, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h7F, 3'd7, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'hFF, 3'd0, 1);
    step(1, SR_HOLD, 8'h00, 0, 0, 8'hFF, 3'd0, 0);

    // Seven rotates, then LOAD at cnt=7 suppresses the pulse; then en_i=0 holds
    step(1, SR_LOAD, 8'h3C, 0, 0, 8'h3C, 3'd0, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'h78, 3'd1, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'hF0, 3'd2, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'hE1, 3'd3, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'hC3, 3'd4, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'h87, 3'd5, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'h0F, 3'd6, 0);
    step(1, SR_ROL, 8'h00, 0, 0, 8'h1E, 3'd7, 0);
    step(1, SR_LOAD, 8'h11, 0, 0, 8'h11, 3'd0, 0);
    for (int i = 0; i < 4; i++)
      step(0, SR_SHR, 8'h00, 1, 1, 8'h11, 3'd0, 0);

    // Reserved mode, SHR, HOLD, CLEAR
    step(1, SR_LOAD, 8'h5A, 0, 0, 8'h5A, 3'd0, 0);
    step(1, SR_RSVD, 8'h00, 1, 1, 8'h5A, 3'd0, 0);
    step(1, SR_SHR, 8'h00, 0, 1, 8'hAD, 3'd1, 0);
    step(1, SR_HOLD, 8'h00, 1, 1, 8'hAD, 3'd1, 0);
    step(1, SR_CLEAR, 8'h00, 0, 0, 8'h00, 3'd0, 0);
    drain();
    check("CLEAR ignores RESET_VAL", 32'(bus1.sr_o), 32'h00);

    // Reset asserted mid-frame between edges
    step(1, SR_LOAD, 8'hA5, 0, 0, 8'hA5, 3'd0, 0);
    step(1, SR_SHL, 8'h00, 0, 0, 8'h4A, 3'd1, 0);
    step(1, SR_SHL, 8'h00, 0, 0, 8'h94, 3'd2, 0);
    step(1, SR_SHL, 8'h00, 0, 0, 8'h28, 3'd3, 0);
    drain();
    bus0.en_i   = 1'b0;
    bus0.mode_i = SR_HOLD;
    #1;
    reset = 1'b1;
    #1;
    check("async reset sr_o",   32'(bus0.sr_o), 32'h00);
    check("async reset cnt_o",  32'(bus0.cnt_o), 32'h0);
    check("async reset done",   32'(bus0.frame_done_o), 32'h0);
    check("async reset sr_o u1",32'(bus1.sr_o), 32'hFF);
    @(negedge clk);
    reset = 1'b0;
    step(1, SR_HOLD, 8'h00, 0, 0, 8'h00, 3'd0, 0);
    step(1, SR_SHL, 8'h00, 1, 0, 8'h01, 3'd1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
